checksum_stream_ctrl: RTL and testbench



---
 rtl/checksum_pkg.sv | 27 ++
 rtl/checksum_beat_sum.sv | 45 ++++
 rtl/checksum_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_checksum_stream_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// Shared types and helpers for the one's-complement checksum stream controller.
// Holds the default word width, the end-around fold and the controller state encoding.
package checksum_pkg;

   localparam int SUM_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } cs_state_t;

   // Enough passes to squeeze any 64-bit operand into 8..32-bit words;
   // once the carry is gone further passes are no-ops.
   function automatic logic [63:0] cs_fold(input logic [63:0] value, input int width);
      logic [63:0] mask;
      logic [63:0] v;
      mask = (64'd1 << width) - 64'd1;
      v    = value;
      for (int i = 0; i < 8; i++) begin
         v = (v & mask) + (v >> width);
      end
      return v;
   endfunction

endpackage

// File: rtl/checksum_beat_sum.sv
// Combinational beat reducer: zeroes disabled tail bytes on the last beat, then sums
// the beat's SUM_W-bit words through a balanced adder tree without dropping carries.
module checksum_beat_sum #(
   parameter int DATA_W = 32,
   parameter int SUM_W  = 16,
   parameter int KEEP_W = DATA_W / 8
) (
   input  logic [DATA_W-1:0]                       data_i,
   input  logic [KEEP_W-1:0]                       keep_i,
   input  logic                                    last_i,
   output logic [SUM_W+$clog2(DATA_W/SUM_W)-1:0]   sum_o
);

   localparam int N   = DATA_W / SUM_W;
   localparam int LVL = $clog2(N);
   localparam int TW  = SUM_W + LVL;

   logic [DATA_W-1:0] masked;

   // keep_i[b] guards the byte at data_i[8b +: 8], so the MSB of keep is the first wire byte.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      masked = data_i;
      for (int b = 0; b < KEEP_W; b++) begin
         if (last_i && !keep_i[b]) begin
            masked[8*b +: 8] = 8'h00;
         end
      end
   end

   // Level 0 holds the N words; every level above halves the count and gains one carry bit.
   for (genvar l = 0; l <= LVL; l++) begin : g_lvl
      logic [(N>>l)-1:0][TW-1:0] node;
      for (genvar i = 0; i < (N >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            assign node[i] = TW'(masked[i*SUM_W +: SUM_W]);
         end else begin : g_add
            assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
         end
      end
   end

   assign sum_o = g_lvl[LVL].node[0];

endmodule

// File: rtl/checksum_stream_ctrl.sv
// Streaming one's-complement checksum sequencer: beat reduction (stage 1), end-around
// accumulation seeded by the pseudo-header sum (stage 2), and a held valid/ready result.
module checksum_stream_ctrl
   import checksum_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SUM_W  = SUM_W_DEF,
   parameter int KEEP_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              sop_i,
   input  logic              last_i,
   input  logic [SUM_W-1:0]  seed_i,
   output logic              cs_valid_o,
   input  logic              cs_ready_i,
   output logic [SUM_W-1:0]  cs_o,
   output logic              err_o
);

   localparam int N  = DATA_W / SUM_W;
   localparam int TW = SUM_W + $clog2(N);

   cs_state_t        state_q, state_d;
   logic [TW-1:0]    part_q, part_d;
   logic             part_vld_q, part_vld_d;
   logic             part_sop_q, part_sop_d;
   logic [SUM_W-1:0] seed_q, seed_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic             err_q, err_d;

   logic [TW-1:0]    beat_sum;
   logic             accept;
   logic             load;
   logic [SUM_W-1:0] part_fold;
   logic [SUM_W-1:0] acc_base;
   logic [SUM_W-1:0] acc_sum;

   checksum_beat_sum #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W),
      .KEEP_W (KEEP_W)
   ) u_beat_sum (
      .data_i (data_i),
      .keep_i (keep_i),
      .last_i (last_i),
      .sum_o  (beat_sum)
   );

   assign ready_o = (state_q == IDLE) || (state_q == ACC);
   assign accept  = valid_i && ready_o;
   // A beat without sop in IDLE is consumed but never enters the pipeline.
   assign load    = accept && (sop_i || (state_q == ACC));

   // Stage 2: fold the partial sum, then fold it into the base; a sop beat replaces the base.
   always_comb begin
      part_fold = SUM_W'(cs_fold(64'(part_q), SUM_W));
      acc_base  = part_sop_q ? seed_q : acc_q;
      acc_sum   = SUM_W'(cs_fold(64'(acc_base) + 64'(part_fold), SUM_W));
   end

   always_comb begin
      state_d    = state_q;
      part_d     = part_q;
      part_vld_d = 1'b0;
      part_sop_d = 1'b0;
      seed_d     = seed_q;
      acc_d      = acc_q;
      err_d      = 1'b0;

      if (part_vld_q) begin
         acc_d = acc_sum;
      end

      if (load) begin
         part_d     = beat_sum;
         part_vld_d = 1'b1;
         part_sop_d = sop_i;
         if (sop_i) begin
            seed_d = seed_i;
         end
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sop_i) begin
                  state_d = last_i ? FLUSH : ACC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACC: begin
            if (accept) begin
               err_d = sop_i;
               if (last_i) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: state_d = DONE;
         DONE: begin
            if (cs_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         part_q     <= '0;
         part_vld_q <= 1'b0;
         part_sop_q <= 1'b0;
         seed_q     <= '0;
         acc_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         part_q     <= part_d;
         part_vld_q <= part_vld_d;
         part_sop_q <= part_sop_d;
         seed_q     <= seed_d;
         acc_q      <= acc_d;
         err_q      <= err_d;
      end
   end

   // The accumulator is frozen in DONE, which keeps cs_o stable under backpressure.
   assign cs_valid_o = (state_q == DONE);
   assign cs_o       = cs_valid_o ? ~acc_q : '0;
   assign err_o      = err_q;

endmodule

// File: tb/tb_checksum_stream_ctrl.sv
// Self-checking bench for checksum_stream_ctrl: directed checksum vectors, protocol
// violations, resets, then random packets checked against a whole-packet sum model.
module tb_checksum_stream_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_i;
   logic [3:0]  keep_i;
   logic        sop_i;
   logic        last_i;
   logic [15:0] seed_i;
   logic        cs_valid_o;
   logic        cs_ready_i;
   logic [15:0] cs_o;
   logic        err_o;

   int errors = 0;
   int checks = 0;

   // Model: unfolded running total of the packet's 16-bit words plus seed.
   longint unsigned m_sum    = 0;
   logic            m_in_pkt = 1'b0;

   checksum_stream_ctrl #(
      .DATA_W (32),
      .SUM_W  (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_i     (data_i),
      .keep_i     (keep_i),
      .sop_i      (sop_i),
      .last_i     (last_i),
      .seed_i     (seed_i),
      .cs_valid_o (cs_valid_o),
      .cs_ready_i (cs_ready_i),
      .cs_o       (cs_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] fold_total(input longint unsigned t);
      longint unsigned v;
      v = t;
      while (v > 64'd65535) begin
         v = (v % 64'd65536) + (v / 64'd65536);
      end
      return 16'(v);
   endfunction

   function automatic logic [15:0] model_cs();
      return ~fold_total(m_sum);
   endfunction

   // Applies one accepted beat to the model; returns whether err_o must pulse.
   function automatic logic model_beat(input logic [31:0] d, input logic [3:0] k,
                                       input logic s, input logic l, input logic [15:0] sd);
      logic [7:0] b [4];
      logic       e;
      e = (m_in_pkt && s) || (!m_in_pkt && !s);
      if (!m_in_pkt && !s) return e;
      if (s) m_sum = 64'(sd);
      for (int i = 0; i < 4; i++) begin
         b[i] = d[31-8*i -: 8];
         if (l && !k[3-i]) b[i] = 8'h00;
      end
      m_sum    = m_sum + 64'({b[0], b[1]}) + 64'({b[2], b[3]});
      m_in_pkt = !l;
      return e;
   endfunction

   task automatic idle_inputs();
      valid_i = 1'b0;
      sop_i   = 1'b0;
      last_i  = 1'b0;
      data_i  = $urandom;
      keep_i  = 4'($urandom);
      seed_i  = 16'($urandom);
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic s, input logic l, input logic [15:0] sd);
      logic exp_err;
      check("ready_before_beat", 32'(ready_o), 32'd1);
      valid_i = 1'b1;
      data_i  = d;
      keep_i  = k;
      sop_i   = s;
      last_i  = l;
      seed_i  = sd;
      exp_err = model_beat(d, k, s, l, sd);
      tick();
      idle_inputs();
      check("err_after_beat", 32'(err_o), 32'(exp_err));
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("err_idle", 32'(err_o), 32'd0);
      end
   endtask

   // Called in the cycle after the last beat was accepted (t+1).
   task automatic expect_result(input logic [15:0] exp_cs, input int hold);
      check("flush_valid", 32'(cs_valid_o), 32'd0);
      check("flush_ready", 32'(ready_o), 32'd0);
      tick();
      check("done_valid", 32'(cs_valid_o), 32'd1);
      check("cs_value", 32'(cs_o), 32'(exp_cs));
      check("done_ready", 32'(ready_o), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 32'(cs_valid_o), 32'd1);
         check("hold_cs", 32'(cs_o), 32'(exp_cs));
         check("hold_ready", 32'(ready_o), 32'd0);
      end
      cs_ready_i = 1'b1;
      tick();
      cs_ready_i = 1'b0;
      check("post_valid", 32'(cs_valid_o), 32'd0);
      check("post_ready", 32'(ready_o), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(ready_o), 32'd1);
      check({tag, "_valid"}, 32'(cs_valid_o), 32'd0);
      check({tag, "_cs"}, 32'(cs_o), 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
   endtask

   task automatic send_ipv4(input int n_beats);
      logic [31:0] hdr [5];
      hdr[0] = 32'h45000073;
      hdr[1] = 32'h00004000;
      hdr[2] = 32'h40110000;
      hdr[3] = 32'hc0a80001;
      hdr[4] = 32'hc0a800c7;
      for (int i = 0; i < n_beats; i++) begin
         send_beat(hdr[i], 4'b1111, 1'(i == 0), 1'(i == 4), 16'h0000);
      end
   endtask

   initial begin
      int nb;
      int n_gap;
      int hold;
      logic s;

      reset      = 1'b1;
      cs_ready_i = 1'b0;
      idle_inputs();
      #2;
      check_reset_values("async_reset");
      tick();
      tick();
      reset = 1'b0;
      check_reset_values("after_reset");

      // IPv4 header, standard example.
      send_ipv4(5);
      expect_result(16'hB861, 0);

      // Single odd-length beat, tail byte masked.
      send_beat(32'h12345678, 4'b1110, 1'b1, 1'b1, 16'h0000);
      expect_result(16'h97CB, 0);

      // Seeded sum reaching 0xFFFF gives a zero checksum.
      send_beat(32'hFFFE0000, 4'b1111, 1'b1, 1'b1, 16'h0001);
      expect_result(16'h0000, 0);

      // End-around carry across beats.
      send_beat(32'hFFFFFFFF, 4'b1111, 1'b1, 1'b0, 16'h0000);
      send_beat(32'h00020000, 4'b1111, 1'b0, 1'b1, 16'h0000);
      expect_result(16'hFFFD, 0);

      // Backpressure, then next packet right after the handshake.
      send_ipv4(5);
      expect_result(16'hB861, 3);
      send_beat(32'h12345678, 4'b1110, 1'b1, 1'b1, 16'h0000);
      expect_result(16'h97CB, 0);

      // Stray beat in IDLE is dropped and flagged.
      send_beat(32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 16'h1234);
      gap(1);
      send_beat(32'h12345678, 4'b1110, 1'b1, 1'b1, 16'h0000);
      expect_result(16'h97CB, 0);

      // sop inside a packet restarts accumulation and is flagged.
      send_beat(32'h11112222, 4'b1111, 1'b1, 1'b0, 16'h5555);
      send_beat(32'h12345678, 4'b1110, 1'b1, 1'b1, 16'h0000);
      expect_result(16'h97CB, 0);

      // Reset after beat 2, then the whole packet again.
      send_ipv4(2);
      reset = 1'b1;
      #1;
      check_reset_values("mid_pkt_reset");
      m_in_pkt = 1'b0;
      tick();
      reset = 1'b0;
      send_ipv4(5);
      expect_result(16'hB861, 0);

      // Reset while the result is waiting.
      send_beat(32'h12345678, 4'b1110, 1'b1, 1'b1, 16'h0000);
      tick();
      tick();
      check("done_before_reset", 32'(cs_valid_o), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_values("done_reset");
      tick();
      reset = 1'b0;
      tick();
      check("no_result_after_reset", 32'(cs_valid_o), 32'd0);

      // Random packets with gaps, backpressure, stray beats and mid-packet sop.
      for (int p = 0; p < 40; p++) begin
         nb = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) begin
            send_beat($urandom, 4'($urandom), 1'b0, 1'b0, 16'($urandom));
         end
         for (int b = 0; b < nb; b++) begin
            n_gap = $urandom_range(0, 2);
            gap(n_gap);
            s = (b == 0) || ($urandom_range(0, 9) == 0);
            send_beat($urandom, 4'($urandom), s, 1'(b == nb - 1), 16'($urandom));
         end
         hold = $urandom_range(0, 3);
         expect_result(model_cs(), hold);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
